parking_request_queue: RTL and testbench

- Upstream front-end of the parking lot core.
- Samples raw driver requests (in_mode / out_mode + BCD license_plate), validates them, and buffers them in a small FIFO.
- Presents requests one at a time to the core through a valid/ready handshake. Its outputs are the core's in_mode_internal, out_mode_internal and license_plate_internal, so requests arriving while the elevator is busy are not lost.

---
 rtl/parking_request_queue_pkg.sv | 27 ++
 rtl/parking_request_queue_if.sv | 29 ++
 rtl/parking_request_queue_fifo.sv | 76 +++++++
 rtl/parking_request_queue.sv | 98 +++++++++
 tb/tb_parking_request_queue.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_request_queue_pkg.sv
// Shared constants, entry layout and plate validation for the parking request front-end.
package parking_pkg;

    localparam int PLATE_W = 16;
    localparam int ENTRY_W = 17;
    localparam logic [3:0] NIBBLE_MAX = 4'd9;
    localparam logic MODE_IN  = 1'b1;
    localparam logic MODE_OUT = 1'b0;

    typedef struct packed {
        logic                 mode;
        logic [PLATE_W-1:0]   plate;
    } entry_t;

    // A plate is usable when every digit is a legal BCD digit and it is not all zeros.
    function automatic logic plate_is_valid(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = (plate != '0);
        for (int unsigned i = 0; i < PLATE_W / 4; i++) begin
            if (plate[i*4 +: 4] > NIBBLE_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/parking_request_queue_if.sv
// Request/handshake bundle between the driver-facing inputs, the request queue and the parking core.
interface parking_request_queue_if #(
    parameter int PTR_W  = 2,
    parameter int DROP_W = 8
);
    logic [15:0]       license_plate;
    logic              in_mode;
    logic              out_mode;
    logic              leakage;
    logic              core_ready;
    logic              in_mode_internal;
    logic              out_mode_internal;
    logic [15:0]       license_plate_internal;
    logic [PTR_W:0]    queue_count;
    logic              queue_full;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output license_plate, in_mode, out_mode, leakage, core_ready,
        input  in_mode_internal, out_mode_internal, license_plate_internal,
        input  queue_count, queue_full, drop_count
    );

    modport slave (
        input  license_plate, in_mode, out_mode, leakage, core_ready,
        output in_mode_internal, out_mode_internal, license_plate_internal,
        output queue_count, queue_full, drop_count
    );
endinterface

// File: rtl/parking_request_queue_fifo.sv
// Generic synchronous FIFO with asynchronous reset; also exposes the head that will be current after the next edge.
module parking_req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] next_head,
    output logic             next_valid,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE        = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_plus;
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W:0]   count_next;

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign count_next  = count + (push_ok ? ONE : '0) - (pop_ok ? ONE : '0);
    assign next_valid  = (count_next != '0);
    assign rd_ptr_plus = rd_ptr + PTR_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_plus;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // With one entry left and a pop, the incoming word has not reached mem yet, so forward it.
    always_comb begin
        next_head = '0;
        if (pop_ok) begin
            if (count > ONE) begin
                next_head = mem[rd_ptr_plus];
            end else if (push_ok) begin
                next_head = push_data;
            end
        end else if (!empty) begin
            next_head = mem[rd_ptr];
        end else if (push_ok) begin
            next_head = push_data;
        end
    end

endmodule

// File: rtl/parking_request_queue.sv
// Validates raw driver requests, queues them and presents them to the parking core one at a time.
// Optional build macro LEAK_HOLD_EN: withhold entry requests at the head while leakage is high.
module parking_request_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DROP_W = 8
) (
    input logic                  clock,
    input logic                  reset,
    parking_request_queue_if.slave bus
);

    import parking_pkg::*;

    logic               both_strobes;
    logic               request;
    logic               plate_ok;
    logic               valid_request;
    logic               pop;
    logic               reject;
    logic               hold;
    logic               next_valid;
    logic               present;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_W:0]     fifo_count;
    entry_t             request_entry;
    entry_t             head_next;

    logic               in_q;
    logic               out_q;
    logic [PLATE_W-1:0] plate_q;
    logic [DROP_W-1:0]  drop_q;

    assign both_strobes  = bus.in_mode & bus.out_mode;
    assign request       = bus.in_mode ^ bus.out_mode;
    assign plate_ok      = plate_is_valid(bus.license_plate);
    assign valid_request = request && plate_ok;
    assign request_entry = '{mode: bus.in_mode, plate: bus.license_plate};
    assign pop           = (in_q | out_q) & bus.core_ready & !fifo_empty;
    assign reject        = both_strobes || (request && !plate_ok) || (valid_request && fifo_full && !pop);

    parking_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (valid_request),
        .push_data  (request_entry),
        .pop        (pop),
        .next_head  (head_next),
        .next_valid (next_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifdef LEAK_HOLD_EN
    assign hold = bus.leakage && (head_next.mode == MODE_IN);
`else
    logic leakage_unused;
    assign leakage_unused = bus.leakage;
    assign hold           = 1'b0;
`endif

    assign present = next_valid && !hold;

    // Outputs are loaded from the post-edge head so a fresh push shows up one cycle after sampling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q    <= 1'b0;
            out_q   <= 1'b0;
            plate_q <= '0;
        end else begin
            in_q    <= present && (head_next.mode == MODE_IN);
            out_q   <= present && (head_next.mode == MODE_OUT);
            plate_q <= present ? head_next.plate : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (reject && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign bus.in_mode_internal       = in_q;
    assign bus.out_mode_internal      = out_q;
    assign bus.license_plate_internal = plate_q;
    assign bus.queue_count            = fifo_count;
    assign bus.queue_full             = fifo_full;
    assign bus.drop_count             = drop_q;

endmodule

// File: tb/tb_parking_request_queue.sv
// Bench for parking_request_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_parking_request_queue;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int DROP_W = 8;
`ifdef LEAK_HOLD_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    parking_request_queue_if #(.PTR_W(PTR_W), .DROP_W(DROP_W)) bus ();

    parking_request_queue #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DROP_W (DROP_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: queue of {mode, plate}, drop total, and what should be on the outputs.
    logic [16:0] mq[$];
    int          exp_drop;
    logic        exp_in;
    logic        exp_out;
    logic [15:0] exp_plate;

    function automatic bit bcd_plate_ok(input logic [15:0] p);
        int digit;
        for (int i = 0; i < 4; i++) begin
            digit = (int'(p) >> (4 * i)) % 16;
            if (digit > 9) return 1'b0;
        end
        return p != 16'h0000;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_drop  = 0;
        exp_in    = 1'b0;
        exp_out   = 1'b0;
        exp_plate = 16'h0000;
    endtask

    task automatic model_edge();
        bit accepted;
        bit dropped;
        accepted = (exp_in || exp_out) && bus.core_ready;
        if (accepted) void'(mq.pop_front());
        dropped = 1'b0;
        if (bus.in_mode && bus.out_mode) begin
            dropped = 1'b1;
        end else if (bus.in_mode != bus.out_mode) begin
            if (!bcd_plate_ok(bus.license_plate) || mq.size() >= DEPTH) dropped = 1'b1;
            else mq.push_back({bus.in_mode, bus.license_plate});
        end
        if (dropped && exp_drop < 255) exp_drop++;
        exp_in = 1'b0; exp_out = 1'b0; exp_plate = 16'h0000;
        if (mq.size() > 0) begin
            if (!(LEAK_EN && bus.leakage && mq[0][16])) begin
                exp_in    = mq[0][16];
                exp_out   = !mq[0][16];
                exp_plate = mq[0][15:0];
            end
        end
    endtask

    task automatic drive(input logic im, input logic om, input logic [15:0] p, input logic rdy, input logic lk);
        bus.in_mode       = im;
        bus.out_mode      = om;
        bus.license_plate = p;
        bus.core_ready    = rdy;
        bus.leakage       = lk;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.in_mode_internal !== 1'b0) $display("FAIL reset_in: got %b want 0", bus.in_mode_internal); else passed++;
        checks++; if (bus.out_mode_internal !== 1'b0) $display("FAIL reset_out: got %b want 0", bus.out_mode_internal); else passed++;
        checks++; if (bus.license_plate_internal !== 16'h0000) $display("FAIL reset_plate: got %h want 0000", bus.license_plate_internal); else passed++;
        checks++; if (bus.queue_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.queue_count); else passed++;
        checks++; if (bus.queue_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.queue_full); else passed++;
        checks++; if (bus.drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", bus.drop_count); else passed++;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 1'b0, 16'h9423, 1'b0, 1'b0);
        tick();
        checks++; if (bus.in_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h9423) $display("FAIL single_present: got in=%b plate=%h want in=1 plate=9423", bus.in_mode_internal, bus.license_plate_internal); else passed++;
        checks++; if (bus.queue_count !== 3'd1) $display("FAIL single_count: got %0d want 1", bus.queue_count); else passed++;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checks++; if (bus.in_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h9423) $display("FAIL single_hold: got in=%b plate=%h want in=1 plate=9423", bus.in_mode_internal, bus.license_plate_internal); else passed++;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checks++; if (bus.queue_count !== 3'd0 || bus.in_mode_internal !== 1'b0) $display("FAIL single_pop: got count=%0d in=%b want count=0 in=0", bus.queue_count, bus.in_mode_internal); else passed++;
    endtask

    task automatic test_order();
        logic [16:0] want [3];
        want[0] = {1'b1, 16'h8754};
        want[1] = {1'b0, 16'h8754};
        want[2] = 17'h0;
        do_reset();
        drive(1'b1, 1'b0, 16'h9423, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 16'h8754, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 16'h8754, 1'b0, 1'b0); tick();
        checks++; if (bus.queue_count !== 3'd3) $display("FAIL order_count: got %0d want 3", bus.queue_count); else passed++;
        checks++; if (bus.in_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h9423) $display("FAIL order_head0: got in=%b plate=%h want in=1 plate=9423", bus.in_mode_internal, bus.license_plate_internal); else passed++;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.in_mode_internal !== want[i][16] || bus.out_mode_internal !== (want[i] != 17'h0 && !want[i][16]) || bus.license_plate_internal !== want[i][15:0])
                $display("FAIL order_head%0d: got in=%b out=%b plate=%h want entry %h", i + 1, bus.in_mode_internal, bus.out_mode_internal, bus.license_plate_internal, want[i]);
            else passed++;
        end
    endtask

    task automatic test_invalid();
        do_reset();
        drive(1'b1, 1'b0, 16'h12A4, 1'b0, 1'b0); tick();
        checks++; if (bus.drop_count !== 8'd1 || bus.queue_count !== 3'd0) $display("FAIL invalid_nibble: got drop=%0d count=%0d want drop=1 count=0", bus.drop_count, bus.queue_count); else passed++;
        drive(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0); tick();
        checks++; if (bus.drop_count !== 8'd2 || bus.queue_count !== 3'd0) $display("FAIL invalid_both: got drop=%0d count=%0d want drop=2 count=0", bus.drop_count, bus.queue_count); else passed++;
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0); tick();
        checks++; if (bus.drop_count !== 8'd3 || bus.queue_count !== 3'd0) $display("FAIL invalid_zero: got drop=%0d count=%0d want drop=3 count=0", bus.drop_count, bus.queue_count); else passed++;
        checks++; if (bus.in_mode_internal !== 1'b0 || bus.out_mode_internal !== 1'b0) $display("FAIL invalid_outputs: got in=%b out=%b want 0 0", bus.in_mode_internal, bus.out_mode_internal); else passed++;
    endtask

    task automatic test_full();
        logic [15:0] drain [4];
        drain[0] = 16'h1002; drain[1] = 16'h1003; drain[2] = 16'h1004; drain[3] = 16'h1006;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.queue_full !== 1'b1 || bus.queue_count !== 3'd4) $display("FAIL full_flag: got full=%b count=%0d want full=1 count=4", bus.queue_full, bus.queue_count); else passed++;
        drive(1'b1, 1'b0, 16'h1005, 1'b0, 1'b0); tick();
        checks++; if (bus.drop_count !== 8'd1 || bus.queue_count !== 3'd4) $display("FAIL full_reject: got drop=%0d count=%0d want drop=1 count=4", bus.drop_count, bus.queue_count); else passed++;
        drive(1'b1, 1'b0, 16'h1006, 1'b1, 1'b0); tick();
        checks++; if (bus.queue_count !== 3'd4 || bus.drop_count !== 8'd1 || bus.license_plate_internal !== 16'h1002) $display("FAIL full_push_pop: got count=%0d drop=%0d plate=%h want count=4 drop=1 plate=1002", bus.queue_count, bus.drop_count, bus.license_plate_internal); else passed++;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.license_plate_internal !== drain[i]) $display("FAIL full_drain%0d: got %h want %h", i, bus.license_plate_internal, drain[i]); else passed++;
            tick();
        end
        checks++; if (bus.queue_count !== 3'd0 || bus.license_plate_internal !== 16'h0000) $display("FAIL full_empty: got count=%0d plate=%h want 0 0000", bus.queue_count, bus.license_plate_internal); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 16'h3141, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 16'h2718, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 16'h1618, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checks++; if (bus.queue_count !== 3'd2 || bus.drop_count !== 8'd1 || bus.out_mode_internal !== 1'b1) $display("FAIL areset_setup: got count=%0d drop=%0d out=%b want 2 1 1", bus.queue_count, bus.drop_count, bus.out_mode_internal); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_mode_internal !== 1'b0 || bus.out_mode_internal !== 1'b0 || bus.license_plate_internal !== 16'h0000 || bus.queue_count !== 3'd0 || bus.queue_full !== 1'b0 || bus.drop_count !== 8'd0)
            $display("FAIL areset_outputs: got in=%b out=%b plate=%h count=%0d full=%b drop=%0d want all zero", bus.in_mode_internal, bus.out_mode_internal, bus.license_plate_internal, bus.queue_count, bus.queue_full, bus.drop_count);
        else passed++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) tick();
        checks++; if (bus.drop_count !== 8'd255 || bus.queue_count !== 3'd0) $display("FAIL saturate: got drop=%0d count=%0d want 255 0", bus.drop_count, bus.queue_count); else passed++;
    endtask

    task automatic test_leakage();
        do_reset();
        drive(1'b1, 1'b0, 16'h5521, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        if (LEAK_EN) begin
            checks++; if (bus.in_mode_internal !== 1'b0 || bus.out_mode_internal !== 1'b0 || bus.license_plate_internal !== 16'h0000) $display("FAIL leak_hold: got in=%b out=%b plate=%h want 0 0 0000", bus.in_mode_internal, bus.out_mode_internal, bus.license_plate_internal); else passed++;
            checks++; if (bus.queue_count !== 3'd2) $display("FAIL leak_count: got %0d want 2", bus.queue_count); else passed++;
            drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
            checks++; if (bus.in_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h5521 || bus.queue_count !== 3'd2) $display("FAIL leak_release: got in=%b plate=%h count=%0d want 1 5521 2", bus.in_mode_internal, bus.license_plate_internal, bus.queue_count); else passed++;
            tick();
            checks++; if (bus.out_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h1234 || bus.queue_count !== 3'd1) $display("FAIL leak_next: got out=%b plate=%h count=%0d want 1 1234 1", bus.out_mode_internal, bus.license_plate_internal, bus.queue_count); else passed++;
        end else begin
            checks++; if (bus.queue_count !== 3'd0 || bus.in_mode_internal !== 1'b0) $display("FAIL leak_ignored: got count=%0d in=%b want 0 0", bus.queue_count, bus.in_mode_internal); else passed++;
            do_reset();
            drive(1'b1, 1'b0, 16'h5521, 1'b0, 1'b1); tick();
            checks++; if (bus.in_mode_internal !== 1'b1 || bus.license_plate_internal !== 16'h5521) $display("FAIL leak_ignored_head: got in=%b plate=%h want 1 5521", bus.in_mode_internal, bus.license_plate_internal); else passed++;
        end
    endtask

    task automatic test_random();
        int r;
        logic im, om, rdy, lk;
        logic [15:0] p;
        logic [30:0] got, want;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 99);
            im = (r < 35) || (r >= 65 && r < 70);
            om = (r >= 35 && r < 70);
            r  = $urandom_range(0, 19);
            if (r == 0) p = 16'h0000;
            else if (r == 1) p = 16'($urandom);
            else p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rdy = ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            lk  = ($urandom_range(0, 9) < 3);
            drive(im, om, p, rdy, lk);
            tick();
            got  = {bus.in_mode_internal, bus.out_mode_internal, bus.license_plate_internal, bus.queue_count, bus.queue_full, bus.drop_count};
            want = {exp_in, exp_out, exp_plate, 3'(mq.size()), mq.size() == DEPTH, 8'(exp_drop)};
            checks++;
            if (got !== want) $display("FAIL random_cycle%0d: got in/out/plate/count/full/drop=%h want %h", c, got, want);
            else passed++;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        model_clear();
        test_reset();
        test_single();
        test_order();
        test_invalid();
        test_full();
        test_async_reset();
        test_saturate();
        test_leakage();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
